// File: rtl/ram_port_copy_engine.sv
// ram_port_copy_engine
// Byte-by-byte block copier that drives one port of a partitioned dual-port RAM.
// Every request is range-checked against this port's partition before any memory
// access. Completion and errors are reported through done/error/err_code.
module ram_port_copy_engine #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int PART_BASE   = 0,
    parameter int PART_SIZE   = 1024,
    parameter int RD_LAT      = 1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] bytes_done,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_wr_ack,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [1:0]        RD_LAST  = 2'(RD_LAT - 1);
    localparam logic [TW-1:0]     ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W+1:0] BASE_X   = (ADDR_W+2)'(PART_BASE);
    localparam logic [ADDR_W+1:0] SIZE_X   = (ADDR_W+2)'(PART_SIZE);

    state_t            state;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        rd_cnt;
    logic [TW-1:0]     ack_cnt;

    logic [ADDR_W+1:0] src_off;
    logic [ADDR_W+1:0] dst_off;
    logic              range_bad;

    // Partition check: an address below the base wraps the offset so its MSB is set;
    // otherwise the offset plus length must not run past the end of the partition.
    always_comb begin
        src_off   = {2'b00, src_r} - BASE_X;
        dst_off   = {2'b00, dst_r} - BASE_X;
        range_bad = src_off[ADDR_W+1] | dst_off[ADDR_W+1]
                  | ((src_off + {2'b00, len_r}) > SIZE_X)
                  | ((dst_off + {2'b00, len_r}) > SIZE_X);
    end

    // Copy FSM; all outputs are registered here, mem_data_out doubles as the read holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            src_r        <= '0;
            dst_r        <= '0;
            len_r        <= '0;
            idx          <= '0;
            rd_cnt       <= '0;
            ack_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
            bytes_done   <= '0;
            mem_wr_en    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r      <= src_addr;
                        dst_r      <= dst_addr;
                        len_r      <= length;
                        error      <= 1'b0;
                        err_code   <= 2'b00;
                        bytes_done <= '0;
                        busy       <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    idx <= '0;
                    if (range_bad) begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        err_code <= 2'b01;
                        state    <= S_ERR;
                    end else if (len_r == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= src_r;
                        state     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    rd_cnt <= '0;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rd_cnt == RD_LAST) begin
                        mem_data_out <= mem_rd_data;
                        mem_wr_en    <= 1'b1;
                        mem_addr     <= dst_r + idx;
                        ack_cnt      <= '0;
                        state        <= S_WR_REQ;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                S_WR_REQ: begin
                    state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (mem_wr_ack) begin
                        bytes_done <= bytes_done + 1'b1;
                        idx        <= idx + 1'b1;
                        if ((idx + 1'b1) == len_r) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= src_r + idx + 1'b1;
                            state     <= S_RD_REQ;
                        end
                    end else if (ack_cnt == ACK_LAST) begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        state    <= S_ERR;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
